// File: rtl/ascii_stream_writer_pkg.sv
// Shared types and character codes for the ASCII stream writer and its cursor.
package ascii_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    WRITE,
    GAP
  } state_t;

  typedef enum logic [2:0] {
    CUR_HOLD,
    CUR_ADVANCE,
    CUR_NEWLINE,
    CUR_RETURN,
    CUR_HOME,
    CUR_BACK
  } cursor_op_t;

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_SPACE = 8'h20;

endpackage

// File: rtl/ascii_stream_writer_cursor.sv
// Text cursor: column, row and a running row base address so the cell address
// needs no multiplier. Wraps to the top of the screen instead of scrolling.
module ascii_cursor
  import ascii_stream_pkg::*;
#(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 60,
  parameter int unsigned ADDR_W = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  input  cursor_op_t                op,
  output logic [$clog2(COLS)-1:0]   col,
  output logic [$clog2(ROWS)-1:0]   row,
  output logic [ADDR_W-1:0]         cell_addr_c
);

  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  logic [ADDR_W-1:0] row_base;
  logic              row_wrap;
  logic [ROW_W-1:0]  row_next;
  logic [ADDR_W-1:0] base_next;

  // Next-row values shared by advance-past-end-of-line and newline.
  always_comb begin
    row_wrap  = (row == LAST_ROW);
    row_next  = row_wrap ? '0 : row + ROW_W'(1);
    base_next = row_wrap ? '0 : row_base + ADDR_W'(COLS);
  end

  assign cell_addr_c = row_base + ADDR_W'(col);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else begin
      case (op)
        CUR_ADVANCE: begin
          if (col == LAST_COL) begin
            col      <= '0;
            row      <= row_next;
            row_base <= base_next;
          end else begin
            col <= col + COL_W'(1);
          end
        end
        CUR_NEWLINE: begin
          col      <= '0;
          row      <= row_next;
          row_base <= base_next;
        end
        CUR_RETURN: begin
          col <= '0;
        end
        CUR_HOME: begin
          col      <= '0;
          row      <= '0;
          row_base <= '0;
        end
        CUR_BACK: begin
          // At the home cell the cursor stays put.
          if (col != '0) begin
            col <= col - COL_W'(1);
          end else if (row != '0) begin
            col      <= LAST_COL;
            row      <= row - ROW_W'(1);
            row_base <= row_base - ADDR_W'(COLS);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ascii_stream_writer.sv
// Turns a valid/ready character stream into paced writes to the ASCII text buffer.
// Optional backspace handling is enabled by defining ASCII_STREAM_WRITER_BACKSPACE_EN.
module ascii_stream_writer
  import ascii_stream_pkg::*;
#(
  parameter int unsigned        COLS        = 80,
  parameter int unsigned        ROWS        = 60,
  parameter int unsigned        ADDR_W      = 13,
  parameter int unsigned        CHAR_W      = 8,
  parameter int unsigned        COLOR_W     = 24,
  parameter int unsigned        WRITE_GAP   = 16,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = 24'hFFFFFF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CHAR_W-1:0]           in_char,
  input  logic [COLOR_W-1:0]          in_color,
  output logic                        ascii_write_en,
  output logic [ADDR_W-1:0]           ascii_write_address,
  output logic [CHAR_W+COLOR_W-1:0]   ascii_input,
  output logic [$clog2(COLS)-1:0]     cursor_col,
  output logic [$clog2(ROWS)-1:0]     cursor_row,
  output logic                        busy
);

  localparam int unsigned CELLS    = COLS * ROWS;
  localparam int unsigned DATA_W   = CHAR_W + COLOR_W;
  localparam int unsigned GAP_W    = (WRITE_GAP > 2) ? $clog2(WRITE_GAP) : 1;
  localparam int unsigned GAP_LAST = (WRITE_GAP > 1) ? WRITE_GAP - 2 : 0;
  localparam logic [DATA_W-1:0] BLANK = {CHAR_W'(CH_SPACE), CLEAR_COLOR};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clear_idx_q, clear_idx_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              gap_to_clear_q, gap_to_clear_d;
  logic              write_en_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  cursor_op_t        cur_op;
  logic [ADDR_W-1:0] cell_addr_c;
  logic              accept_c;
  logic              clear_last_c;

  assign accept_c     = in_valid && in_ready;
  assign clear_last_c = (clear_idx_q == ADDR_W'(CELLS - 1));

`ifdef ASCII_STREAM_WRITER_BACKSPACE_EN
  // Cell just before the cursor; the home cell maps onto itself.
  logic [ADDR_W-1:0] back_addr_c;
  assign back_addr_c = (cursor_col == '0 && cursor_row == '0) ? '0
                                                              : cell_addr_c - ADDR_W'(1);
`endif

  ascii_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk         (clk),
    .rst         (rst),
    .op          (cur_op),
    .col         (cursor_col),
    .row         (cursor_row),
    .cell_addr_c (cell_addr_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, next output values and cursor command.
  always_comb begin
    state_d        = state_q;
    clear_idx_d    = clear_idx_q;
    gap_cnt_d      = gap_cnt_q;
    gap_to_clear_d = gap_to_clear_q;
    write_en_d     = 1'b0;
    addr_d         = ascii_write_address;
    data_d         = ascii_input;
    cur_op         = CUR_HOLD;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (in_char == CHAR_W'(CH_LF)) begin
            cur_op = CUR_NEWLINE;
          end else if (in_char == CHAR_W'(CH_CR)) begin
            cur_op = CUR_RETURN;
          end else if (in_char == CHAR_W'(CH_FF)) begin
            state_d     = CLEAR;
            clear_idx_d = '0;
            cur_op      = CUR_HOME;
`ifdef ASCII_STREAM_WRITER_BACKSPACE_EN
          end else if (in_char == CHAR_W'(CH_BS)) begin
            state_d    = WRITE;
            write_en_d = 1'b1;
            addr_d     = back_addr_c;
            data_d     = {CHAR_W'(CH_SPACE), in_color};
            cur_op     = CUR_BACK;
`endif
          end else begin
            state_d    = WRITE;
            write_en_d = 1'b1;
            addr_d     = cell_addr_c;
            data_d     = {in_char, in_color};
            cur_op     = CUR_ADVANCE;
          end
        end
      end

      CLEAR: begin
        // Issue one blank cell; its pulse lands in the following cycle.
        write_en_d = 1'b1;
        addr_d     = clear_idx_q;
        data_d     = BLANK;
        gap_cnt_d  = '0;
        if (clear_last_c) begin
          clear_idx_d    = '0;
          gap_to_clear_d = 1'b0;
          cur_op         = CUR_HOME;
        end else begin
          clear_idx_d    = clear_idx_q + ADDR_W'(1);
          gap_to_clear_d = 1'b1;
        end
        if (WRITE_GAP == 1) begin
          state_d = clear_last_c ? IDLE : CLEAR;
        end else begin
          state_d = GAP;
        end
      end

      WRITE: begin
        gap_cnt_d      = '0;
        gap_to_clear_d = 1'b0;
        state_d        = (WRITE_GAP == 1) ? IDLE : GAP;
      end

      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          state_d = gap_to_clear_q ? CLEAR : IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d     = CLEAR;
        clear_idx_d = '0;
      end
    endcase
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clear_idx_q         <= '0;
      gap_cnt_q           <= '0;
      gap_to_clear_q      <= 1'b0;
      ascii_write_en      <= 1'b0;
      ascii_write_address <= '0;
      ascii_input         <= BLANK;
      in_ready            <= 1'b0;
      busy                <= 1'b1;
    end else begin
      clear_idx_q         <= clear_idx_d;
      gap_cnt_q           <= gap_cnt_d;
      gap_to_clear_q      <= gap_to_clear_d;
      ascii_write_en      <= write_en_d;
      ascii_write_address <= addr_d;
      ascii_input         <= data_d;
      in_ready            <= (state_d == IDLE);
      busy                <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_ascii_stream_writer.sv
// Directed bench for ascii_stream_writer on a 4x3 grid with a 2-cycle write gap.
// Backspace vectors follow ASCII_STREAM_WRITER_BACKSPACE_EN when it is defined.
module tb_ascii_stream_writer;

  localparam int unsigned COLS      = 4;
  localparam int unsigned ROWS      = 3;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned CHAR_W    = 8;
  localparam int unsigned COLOR_W   = 24;
  localparam int unsigned WRITE_GAP = 2;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] BSCOL = 24'h123456;
  localparam logic [31:0] BLANK = {8'h20, WHITE};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic [23:0] in_color;
  logic        ascii_write_en;
  logic [3:0]  ascii_write_address;
  logic [31:0] ascii_input;
  logic [1:0]  cursor_col;
  logic [1:0]  cursor_row;
  logic        busy;

  ascii_stream_writer #(
    .COLS        (COLS),
    .ROWS        (ROWS),
    .ADDR_W      (ADDR_W),
    .CHAR_W      (CHAR_W),
    .COLOR_W     (COLOR_W),
    .WRITE_GAP   (WRITE_GAP),
    .CLEAR_COLOR (WHITE)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_char             (in_char),
    .in_color            (in_color),
    .ascii_write_en      (ascii_write_en),
    .ascii_write_address (ascii_write_address),
    .ascii_input         (ascii_input),
    .cursor_col          (cursor_col),
    .cursor_row          (cursor_row),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ch;
    logic [23:0] color;
    int          nwr;
    int          addr;
    logic [7:0]  wch;
    int          low;
    int          col;
    int          row;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[$];
  wr_t  wlog[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write pulses are logged on the falling edge, away from the DUT's update edge.
  always @(negedge clk) begin
    if (ascii_write_en === 1'b1) wlog.push_back('{cyc, ascii_write_address, ascii_input});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a character at a falling edge and hold it until accepted.
  task automatic accept_char(input logic [7:0] ch, input logic [23:0] color, output int acc);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_char  = ch;
    in_color = color;
    while (in_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("accept_ready", 64'(in_ready), 64'd1);
    acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(input int limit, output int low, output int rcyc);
    low = 0;
    while (in_ready !== 1'b1 && low < limit) begin
      @(negedge clk);
      low++;
    end
    chk("ready_return", 64'(in_ready), 64'd1);
    rcyc = cyc;
  endtask

  // Expects a complete blank-screen sequence in the log, then ready one cycle later.
  task automatic check_clear(input string tag);
    int low, rc;
    wait_ready(300, low, rc);
    chk({tag, "_count"}, 64'(wlog.size()), 64'd12);
    for (int i = 0; i < wlog.size() && i < 12; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 64'(wlog[i].addr), 64'(i));
      chk($sformatf("%s_data%0d", tag, i), 64'(wlog[i].data), 64'(BLANK));
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), 64'(wlog[i].cyc - wlog[i-1].cyc), 64'd2);
    end
    if (wlog.size() > 0) chk({tag, "_ready_cycle"}, 64'(rc), 64'(wlog[wlog.size()-1].cyc + 1));
    chk({tag, "_col"}, 64'(cursor_col), 64'd0);
    chk({tag, "_row"}, 64'(cursor_row), 64'd0);
  endtask

  initial begin
    int acc, low, rc, idx, g;
    int sacc[4];
    logic [7:0] sq[4];

    // ch, color, writes, addr, written char, ready-low cycles, col, row after
    vecs.push_back('{8'h41, GREEN, 1, 0,  8'h41, 2, 1, 0});
    vecs.push_back('{8'h42, GREEN, 1, 1,  8'h42, 2, 2, 0});
    vecs.push_back('{8'h43, GREEN, 1, 2,  8'h43, 2, 3, 0});
    vecs.push_back('{8'h44, GREEN, 1, 3,  8'h44, 2, 0, 1});
    vecs.push_back('{8'h45, GREEN, 1, 4,  8'h45, 2, 1, 1});
    vecs.push_back('{8'h0A, GREEN, 0, 0,  8'h00, 0, 0, 2});
    vecs.push_back('{8'h61, GREEN, 1, 8,  8'h61, 2, 1, 2});
    vecs.push_back('{8'h62, GREEN, 1, 9,  8'h62, 2, 2, 2});
    vecs.push_back('{8'h58, GREEN, 1, 10, 8'h58, 2, 3, 2});
    vecs.push_back('{8'h59, GREEN, 1, 11, 8'h59, 2, 0, 0});
    vecs.push_back('{8'h5A, GREEN, 1, 0,  8'h5A, 2, 1, 0});
    vecs.push_back('{8'h0D, GREEN, 0, 0,  8'h00, 0, 0, 0});
    vecs.push_back('{8'h0A, GREEN, 0, 0,  8'h00, 0, 0, 1});
    vecs.push_back('{8'h0A, GREEN, 0, 0,  8'h00, 0, 0, 2});
    vecs.push_back('{8'h0A, GREEN, 0, 0,  8'h00, 0, 0, 0});
    vecs.push_back('{8'h4D, GREEN, 1, 0,  8'h4D, 2, 1, 0});
    vecs.push_back('{8'h0A, GREEN, 0, 0,  8'h00, 0, 0, 1});
`ifdef ASCII_STREAM_WRITER_BACKSPACE_EN
    vecs.push_back('{8'h08, BSCOL, 1, 3,  8'h20, 2, 3, 0});
    vecs.push_back('{8'h0D, GREEN, 0, 0,  8'h00, 0, 0, 0});
    vecs.push_back('{8'h08, BSCOL, 1, 0,  8'h20, 2, 0, 0});
    vecs.push_back('{8'h0D, GREEN, 0, 0,  8'h00, 0, 0, 0});
    vecs.push_back('{8'h50, GREEN, 1, 0,  8'h50, 2, 1, 0});
    vecs.push_back('{8'h08, BSCOL, 1, 0,  8'h20, 2, 0, 0});
`else
    vecs.push_back('{8'h08, BSCOL, 1, 4,  8'h08, 2, 1, 1});
    vecs.push_back('{8'h0D, GREEN, 0, 0,  8'h00, 0, 0, 1});
    vecs.push_back('{8'h08, BSCOL, 1, 4,  8'h08, 2, 1, 1});
    vecs.push_back('{8'h0D, GREEN, 0, 0,  8'h00, 0, 0, 1});
    vecs.push_back('{8'h50, GREEN, 1, 4,  8'h50, 2, 1, 1});
    vecs.push_back('{8'h08, BSCOL, 1, 5,  8'h08, 2, 2, 1});
`endif

    in_valid = 1'b0;
    in_char  = 8'h00;
    in_color = 24'h0;
    rst      = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_write_en", 64'(ascii_write_en), 64'd0);
    chk("rst_addr", 64'(ascii_write_address), 64'd0);
    chk("rst_data", 64'(ascii_input), 64'(BLANK));
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_col", 64'(cursor_col), 64'd0);
    chk("rst_row", 64'(cursor_row), 64'd0);

    wlog.delete();
    rst = 1'b1;
    check_clear("boot_clear");

    foreach (vecs[i]) begin
      wlog.delete();
      accept_char(vecs[i].ch, vecs[i].color, acc);
      wait_ready(50, low, rc);
      chk($sformatf("vec%0d_ready_low", i), 64'(low), 64'(vecs[i].low));
      chk($sformatf("vec%0d_writes", i), 64'(wlog.size()), 64'(vecs[i].nwr));
      if (vecs[i].nwr > 0 && wlog.size() > 0) begin
        chk($sformatf("vec%0d_addr", i), 64'(wlog[0].addr), 64'(vecs[i].addr));
        chk($sformatf("vec%0d_data", i), 64'(wlog[0].data), 64'({vecs[i].wch, vecs[i].color}));
        chk($sformatf("vec%0d_pulse_cycle", i), 64'(wlog[0].cyc), 64'(acc + 1));
      end
      chk($sformatf("vec%0d_col", i), 64'(cursor_col), 64'(vecs[i].col));
      chk($sformatf("vec%0d_row", i), 64'(cursor_row), 64'(vecs[i].row));
    end

    // "AB" then form-feed: the whole screen is blanked and the cursor forgotten.
    accept_char(8'h41, GREEN, acc);
    wait_ready(50, low, rc);
    accept_char(8'h42, GREEN, acc);
    wait_ready(50, low, rc);
    wlog.delete();
    accept_char(8'h0C, GREEN, acc);
    check_clear("ff_clear");
    wlog.delete();
    accept_char(8'h51, GREEN, acc);
    wait_ready(50, low, rc);
    chk("q_writes", 64'(wlog.size()), 64'd1);
    if (wlog.size() > 0) begin
      chk("q_addr", 64'(wlog[0].addr), 64'd0);
      chk("q_data", 64'(wlog[0].data), 64'({8'h51, GREEN}));
    end
    chk("q_col", 64'(cursor_col), 64'd1);
    chk("q_row", 64'(cursor_row), 64'd0);
    accept_char(8'h0D, GREEN, acc);
    wait_ready(50, low, rc);

    // A, LF, CR, B with in_valid held high the whole time.
    sq[0] = 8'h41; sq[1] = 8'h0A; sq[2] = 8'h0D; sq[3] = 8'h42;
    wlog.delete();
    idx = 0;
    g   = 0;
    in_valid = 1'b1;
    in_color = GREEN;
    while (idx < 4 && g < 100) begin
      in_char = sq[idx];
      if (in_ready === 1'b1) begin
        sacc[idx] = cyc;
        idx++;
      end
      @(negedge clk);
      g++;
    end
    in_valid = 1'b0;
    chk("stream_accepted", 64'(idx), 64'd4);
    if (idx == 4) begin
      chk("stream_gap_a_lf", 64'(sacc[1] - sacc[0]), 64'd3);
      chk("stream_gap_lf_cr", 64'(sacc[2] - sacc[1]), 64'd1);
      chk("stream_gap_cr_b", 64'(sacc[3] - sacc[2]), 64'd1);
    end
    wait_ready(50, low, rc);
    chk("stream_writes", 64'(wlog.size()), 64'd2);
    if (wlog.size() >= 2) begin
      chk("stream_a_addr", 64'(wlog[0].addr), 64'd0);
      chk("stream_a_data", 64'(wlog[0].data), 64'({8'h41, GREEN}));
      chk("stream_b_addr", 64'(wlog[1].addr), 64'd4);
      chk("stream_b_data", 64'(wlog[1].data), 64'({8'h42, GREEN}));
    end
    chk("stream_col", 64'(cursor_col), 64'd1);
    chk("stream_row", 64'(cursor_row), 64'd1);

    // Reset in the middle of a clear: strobe drops at once, clear restarts at 0.
    wlog.delete();
    accept_char(8'h0C, GREEN, acc);
    g = 0;
    while (!(ascii_write_en === 1'b1 && ascii_write_address == 4'd5) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("midclear_at5_en", 64'(ascii_write_en), 64'd1);
    chk("midclear_at5_addr", 64'(ascii_write_address), 64'd5);
    #2 rst = 1'b0;
    #1;
    chk("midclear_rst_write_en", 64'(ascii_write_en), 64'd0);
    chk("midclear_rst_addr", 64'(ascii_write_address), 64'd0);
    chk("midclear_rst_in_ready", 64'(in_ready), 64'd0);
    chk("midclear_rst_busy", 64'(busy), 64'd1);
    @(negedge clk);
    wlog.delete();
    rst = 1'b1;
    check_clear("restart_clear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
